// File: rtl/dec2bin_entry.sv
// Signed decimal keypad entry: debounces four push buttons, accumulates BCD digits
// and commits an 8-bit two's-complement value with a single-cycle strobe.
module dec2bin_entry #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int MAX_DIGITS      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw_digit,
  input  logic       btn_digit,
  input  logic       btn_sign,
  input  logic       btn_commit,
  input  logic       btn_clr,
  output logic [7:0] n,
  output logic       n_valid,
  output logic       neg,
  output logic [9:0] mag,
  output logic [1:0] digit_cnt,
  output logic       err,
  output logic       ovf
);

  // state | meaning
  // IDLE  | no digits entered
  // ENTRY | 1..MAX_DIGITS-1 digits entered
  // FULL  | MAX_DIGITS entered, further digits rejected
  typedef enum logic [1:0] {IDLE, ENTRY, FULL} state_t;

  localparam int              NB      = 4;
  localparam int              CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]   DB_LOAD = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]      MAX_CNT = 2'(MAX_DIGITS);

  // Button index: 0 digit, 1 sign, 2 commit, 3 clear
  logic [NB-1:0]         btn_raw;
  logic [NB-1:0]         sync1_q, sync2_q;
  logic [NB-1:0]         stable_q, stable_d;
  logic [NB-1:0]         press_q, press_d;
  logic [NB-1:0][CW-1:0] db_cnt_q, db_cnt_d;

  assign btn_raw = {btn_clr, btn_commit, btn_sign, btn_digit};

  // Down-counter reloads whenever the synchronised input agrees with the debounced level
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < NB; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        db_cnt_d[i] = DB_LOAD;
      end else if (db_cnt_q[i] == '0) begin
        stable_d[i] = sync2_q[i];
        db_cnt_d[i] = DB_LOAD;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] - 1'b1;
      end
    end
    press_d = stable_d & ~stable_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      press_q  <= '0;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      press_q  <= press_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  state_t     state_q, state_d;
  logic [7:0] n_q, n_d;
  logic       n_valid_q, n_valid_d;
  logic       neg_q, neg_d;
  logic [9:0] mag_q, mag_d;
  logic [1:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       ovf_q, ovf_d;

  logic       clr_p, commit_p, digit_p, sign_p;
  logic [9:0] limit;

  assign clr_p    = press_q[3];
  assign commit_p = press_q[2] & ~clr_p;
  assign digit_p  = press_q[0] & ~press_q[2] & ~clr_p;
  assign sign_p   = press_q[1] & ~press_q[0] & ~press_q[2] & ~clr_p;
  assign limit    = neg_q ? 10'd128 : 10'd127;

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    n_valid_d = 1'b0;
    neg_d     = neg_q;
    mag_d     = mag_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    ovf_d     = ovf_q;

    if (clr_p) begin
      state_d = IDLE;
      neg_d   = 1'b0;
      mag_d   = '0;
      cnt_d   = '0;
      err_d   = 1'b0;
      ovf_d   = 1'b0;
    end else if (commit_p) begin
      if (mag_q <= limit) begin
        n_d       = neg_q ? (~mag_q[7:0] + 8'd1) : mag_q[7:0];
        n_valid_d = 1'b1;
        ovf_d     = 1'b0;
      end else begin
        ovf_d = 1'b1;
      end
      state_d = IDLE;
      neg_d   = 1'b0;
      mag_d   = '0;
      cnt_d   = '0;
    end else if (digit_p) begin
      if ((sw_digit > 4'd9) || (state_q == FULL)) begin
        err_d = 1'b1;
      end else begin
        // 99*10+9 is the largest reachable result, so 10 bits never wrap
        mag_d   = mag_q * 10'd10 + {6'd0, sw_digit};
        cnt_d   = cnt_q + 2'd1;
        state_d = (cnt_d == MAX_CNT) ? FULL : ENTRY;
      end
    end else if (sign_p) begin
      neg_d = ~neg_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      n_q       <= '0;
      n_valid_q <= 1'b0;
      neg_q     <= 1'b0;
      mag_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      n_valid_q <= n_valid_d;
      neg_q     <= neg_d;
      mag_q     <= mag_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      ovf_q     <= ovf_d;
    end
  end

  assign n         = n_q;
  assign n_valid   = n_valid_q;
  assign neg       = neg_q;
  assign mag       = mag_q;
  assign digit_cnt = cnt_q;
  assign err       = err_q;
  assign ovf       = ovf_q;

endmodule
